// File: rtl/arb_rr_lock_pipe_if.sv
// Handshake bundle for arb_rr_lock_pipe: WIDTH upstream valid/ready/last
// channels and one registered downstream channel tagged with a source id.
interface arb_rr_lock_pipe_if #(
  parameter type         PLD_TYPE = logic,
  parameter int unsigned WIDTH    = 4
);
  localparam int unsigned ID_W = $clog2(WIDTH);

  logic [WIDTH-1:0] v_vld_s;
  logic [WIDTH-1:0] v_rdy_s;
  PLD_TYPE          v_pld_s [WIDTH];
  logic [WIDTH-1:0] v_last_s;
  logic             vld_m;
  logic             rdy_m;
  PLD_TYPE          pld_m;
  logic             last_m;
  logic [ID_W-1:0]  id_m;

  // Arbiter side.
  modport master (
    input  v_vld_s,
    input  v_pld_s,
    input  v_last_s,
    input  rdy_m,
    output v_rdy_s,
    output vld_m,
    output pld_m,
    output last_m,
    output id_m
  );

  // Environment side: upstream sources plus downstream consumer.
  modport slave (
    output v_vld_s,
    output v_pld_s,
    output v_last_s,
    output rdy_m,
    input  v_rdy_s,
    input  vld_m,
    input  pld_m,
    input  last_m,
    input  id_m
  );
endinterface

// File: rtl/arb_rr_lock_pipe.sv
// N-to-1 packet-locking arbiter (fixed priority or round-robin) feeding a
// single full-throughput output register {pld, last, id, vld}.
module arb_rr_lock_pipe #(
  parameter type         PLD_TYPE = logic,
  parameter int unsigned WIDTH    = 4,
  parameter bit          RR_MODE  = 1'b1
) (
  input logic                clk,
  input logic                rst,
  arb_rr_lock_pipe_if.master bus
);
  localparam int unsigned ID_W = $clog2(WIDTH);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_e;

  lock_state_e     lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            vld_q, vld_d;
  logic            last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  PLD_TYPE         pld_q, pld_d;

  logic [WIDTH-1:0] gnt;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  base;
  logic             load;
  logic             accept;
  logic             win_last;

  assign load = !vld_q || bus.rdy_m;
  assign base = RR_MODE ? ptr_q : '0;

  // Search starts at base and wraps explicitly, so non-power-of-2 WIDTH works.
  always_comb begin : arbitrate
    int unsigned idx;
    logic        found;
    gnt   = '0;
    win   = '0;
    idx   = 0;
    found = 1'b0;
    if (rst) begin
      gnt = '0;
    end else if (lock_q == ST_LOCKED) begin
      gnt[lock_id_q] = bus.v_vld_s[lock_id_q];
      win            = lock_id_q;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        idx = int'(base) + i;
        if (idx >= WIDTH) idx = idx - WIDTH;
        if (!found && bus.v_vld_s[idx[ID_W-1:0]]) begin
          gnt[idx[ID_W-1:0]] = 1'b1;
          win                = idx[ID_W-1:0];
          found              = 1'b1;
        end
      end
    end
  end

  assign bus.v_rdy_s = gnt & {WIDTH{load}};
  assign accept      = |(bus.v_vld_s & bus.v_rdy_s);
  assign win_last    = bus.v_last_s[win];

  always_comb begin : next_state
    vld_d     = vld_q;
    pld_d     = pld_q;
    last_d    = last_q;
    id_d      = id_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    ptr_d     = ptr_q;
    if (accept) begin
      vld_d  = 1'b1;
      pld_d  = bus.v_pld_s[win];
      last_d = win_last;
      id_d   = win;
      if (win_last) begin
        lock_d = ST_OPEN;
        if (RR_MODE) ptr_d = (win == ID_W'(WIDTH - 1)) ? '0 : win + 1'b1;
      end else begin
        lock_d    = ST_LOCKED;
        lock_id_d = win;
      end
    end else if (vld_q && bus.rdy_m) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      pld_q     <= '0;
      last_q    <= 1'b0;
      id_q      <= '0;
      lock_q    <= ST_OPEN;
      lock_id_q <= '0;
      ptr_q     <= '0;
    end else begin
      vld_q     <= vld_d;
      pld_q     <= pld_d;
      last_q    <= last_d;
      id_q      <= id_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.vld_m  = vld_q;
  assign bus.pld_m  = pld_q;
  assign bus.last_m = last_q;
  assign bus.id_m   = id_q;
endmodule

// File: tb/tb_arb_rr_lock_pipe.sv
// Bench for arb_rr_lock_pipe: directed arbitration/lock/reset steps on three
// configurations plus a randomized backpressure run against a beat scoreboard.
module tb_arb_rr_lock_pipe;
  typedef logic [7:0] pld_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  arb_rr_lock_pipe_if #(.PLD_TYPE(pld_t), .WIDTH(4)) if_rr4 ();
  arb_rr_lock_pipe_if #(.PLD_TYPE(pld_t), .WIDTH(4)) if_fp4 ();
  arb_rr_lock_pipe_if #(.PLD_TYPE(pld_t), .WIDTH(3)) if_rr3 ();

  arb_rr_lock_pipe #(.PLD_TYPE(pld_t), .WIDTH(4), .RR_MODE(1'b1)) u_rr4 (
    .clk(clk), .rst(rst), .bus(if_rr4.master));
  arb_rr_lock_pipe #(.PLD_TYPE(pld_t), .WIDTH(4), .RR_MODE(1'b0)) u_fp4 (
    .clk(clk), .rst(rst), .bus(if_fp4.master));
  arb_rr_lock_pipe #(.PLD_TYPE(pld_t), .WIDTH(3), .RR_MODE(1'b1)) u_rr3 (
    .clk(clk), .rst(rst), .bus(if_rr3.master));

  // Scoreboard state for the randomized run: per-source beats {last, pld}.
  logic [8:0] drv_q [4][$];
  logic [8:0] ref_q [4][$];
  logic [8:0] exp_beat;
  logic [8:0] held;
  logic [1:0] held_id;
  logic [1:0] pkt_id;
  logic [3:0] cur_vld;
  logic [3:0] acc_prev;
  logic       stall_prev;
  logic       in_pkt;
  int         total_beats;
  int         got_beats;
  int         cyc;
  int         len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_rr4.v_vld_s = '1; if_rr4.v_last_s = '1; if_rr4.rdy_m = 1'b1;
    if_fp4.v_vld_s = '1; if_fp4.v_last_s = '1; if_fp4.rdy_m = 1'b1;
    if_rr3.v_vld_s = '1; if_rr3.v_last_s = '1; if_rr3.rdy_m = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if_rr4.v_pld_s[s] = 8'(8'h40 + s);
      if_fp4.v_pld_s[s] = 8'(8'h20 + s);
    end
    for (int s = 0; s < 3; s++) if_rr3.v_pld_s[s] = 8'(8'h30 + s);

    // Reset held with every source requesting: nothing granted, nothing out.
    @(negedge clk);
    check("rst_rdy_rr4", if_rr4.v_rdy_s, 4'b0000);
    check("rst_rdy_fp4", if_fp4.v_rdy_s, 4'b0000);
    check("rst_vld_rr4", if_rr4.vld_m, 1'b0);
    rst = 1'b0;
    if_rr4.v_vld_s = '0; if_fp4.v_vld_s = '0; if_rr3.v_vld_s = '0;
    repeat (2) @(negedge clk);
    check("idle_vld", if_rr4.vld_m, 1'b0);
    check("idle_id", if_rr4.id_m, 2'd0);
    check("idle_pld", if_rr4.pld_m, 8'h00);
    check("idle_last", if_rr4.last_m, 1'b0);
    check("idle_rdy", if_rr4.v_rdy_s, 4'b0000);

    // Steady single-beat requests: fixed priority vs round-robin order.
    if_fp4.v_vld_s = 4'b1010;
    if_rr4.v_vld_s = 4'b1111;
    if_rr3.v_vld_s = 3'b111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fp_id", if_fp4.id_m, 2'd1);
      check("fp_rdy", if_fp4.v_rdy_s, 4'b0010);
      check("rr4_vld", if_rr4.vld_m, 1'b1);
      check("rr4_id", if_rr4.id_m, 32'(k % 4));
      check("rr4_pld", if_rr4.pld_m, 32'(8'h40 + k % 4));
      check("rr3_vld", if_rr3.vld_m, 1'b1);
      check("rr3_id", if_rr3.id_m, 32'(k % 3));
    end
    if_fp4.v_vld_s = '0; if_rr4.v_vld_s = '0; if_rr3.v_vld_s = '0;
    @(negedge clk);
    check("drain_vld_rr4", if_rr4.vld_m, 1'b0);
    check("drain_vld_fp4", if_fp4.vld_m, 1'b0);

    // Source 1 single beat moves the pointer to 2, so source 2 wins over 0.
    if_rr4.v_vld_s = 4'b0010; if_rr4.v_pld_s[1] = 8'h11;
    @(negedge clk);
    check("lk_pre_id", if_rr4.id_m, 2'd1);
    if_rr4.v_vld_s = 4'b0101; if_rr4.v_last_s = 4'b0001; if_rr4.v_pld_s[0] = 8'hC0;
    for (int b = 0; b < 3; b++) begin
      if (b == 1) begin
        if_rr4.v_vld_s = 4'b0001;
        #1 check("lk_bubble_rdy", if_rr4.v_rdy_s, 4'b0000);
        @(negedge clk);
        check("lk_bubble_vld", if_rr4.vld_m, 1'b0);
        if_rr4.v_vld_s = 4'b0101;
      end
      if_rr4.v_pld_s[2]  = 8'(8'hA0 + b);
      if_rr4.v_last_s[2] = (b == 2);
      #1 check("lk_rdy", if_rr4.v_rdy_s, 4'b0100);
      @(negedge clk);
      check("lk_id", if_rr4.id_m, 2'd2);
      check("lk_pld", if_rr4.pld_m, 32'(8'hA0 + b));
      check("lk_last", if_rr4.last_m, 32'(b == 2));
    end
    // Pointer now 3: source 3 beats source 0.
    if_rr4.v_vld_s = 4'b1001; if_rr4.v_last_s = 4'b1001; if_rr4.v_pld_s[3] = 8'hD3;
    #1 check("lk_ptr3_rdy", if_rr4.v_rdy_s, 4'b1000);
    @(negedge clk);
    check("lk_ptr3_id", if_rr4.id_m, 2'd3);
    if_rr4.v_vld_s = 4'b0001;
    #1 check("lk_src0_rdy", if_rr4.v_rdy_s, 4'b0001);
    @(negedge clk);
    check("lk_src0_id", if_rr4.id_m, 2'd0);
    check("lk_src0_pld", if_rr4.pld_m, 8'hC0);
    if_rr4.v_vld_s = '0;
    @(negedge clk);

    // Randomized packets with 50% downstream backpressure.
    total_beats = 0;
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 4; p++) begin
        len = $urandom_range(1, 5);
        for (int b = 0; b < len; b++) begin
          exp_beat = {b == len - 1, 8'($urandom)};
          drv_q[s].push_back(exp_beat);
          ref_q[s].push_back(exp_beat);
          total_beats++;
        end
      end
    end
    cur_vld = '0; acc_prev = '0; stall_prev = 1'b0; in_pkt = 1'b0;
    got_beats = 0; cyc = 0;
    while (got_beats < total_beats && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stall_prev)
        check("bp_hold", {if_rr4.vld_m, if_rr4.id_m, if_rr4.last_m, if_rr4.pld_m},
              {1'b1, held_id, held});
      for (int s = 0; s < 4; s++) begin
        if (acc_prev[s]) begin
          void'(drv_q[s].pop_front());
          cur_vld[s] = 1'b0;
        end
        if (!cur_vld[s] && drv_q[s].size() != 0 && $urandom_range(0, 3) != 0)
          cur_vld[s] = 1'b1;
        if (cur_vld[s]) {if_rr4.v_last_s[s], if_rr4.v_pld_s[s]} = drv_q[s][0];
        else            {if_rr4.v_last_s[s], if_rr4.v_pld_s[s]} = '0;
      end
      if_rr4.v_vld_s = cur_vld;
      if_rr4.rdy_m   = 1'($urandom_range(0, 1));
      #1;
      check("bp_rdy_onehot", 32'($countones(if_rr4.v_rdy_s) <= 1), 1);
      acc_prev = if_rr4.v_vld_s & if_rr4.v_rdy_s;
      if (if_rr4.vld_m && if_rr4.rdy_m) begin
        check("bp_src_has_beat", 32'(ref_q[if_rr4.id_m].size() != 0), 1);
        if (ref_q[if_rr4.id_m].size() != 0) begin
          exp_beat = ref_q[if_rr4.id_m].pop_front();
          check("bp_beat", {if_rr4.last_m, if_rr4.pld_m}, exp_beat);
        end
        if (in_pkt) check("bp_contig", if_rr4.id_m, pkt_id);
        in_pkt = !if_rr4.last_m;
        pkt_id = if_rr4.id_m;
        got_beats++;
      end
      stall_prev = if_rr4.vld_m && !if_rr4.rdy_m;
      held       = {if_rr4.last_m, if_rr4.pld_m};
      held_id    = if_rr4.id_m;
    end
    check("bp_all_beats", got_beats, total_beats);

    // Reset in the middle of a 3-beat packet from source 1.
    if_rr4.v_vld_s = '0; if_rr4.rdy_m = 1'b1;
    @(negedge clk);
    if_rr4.v_vld_s = 4'b0010; if_rr4.v_last_s = 4'b0000; if_rr4.v_pld_s[1] = 8'h51;
    @(negedge clk);
    check("mr_beat1_vld", if_rr4.vld_m, 1'b1);
    check("mr_beat1_id", if_rr4.id_m, 2'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_rst_vld", if_rr4.vld_m, 1'b0);
    check("mr_rst_rdy", if_rr4.v_rdy_s, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    check("mr_post_vld", if_rr4.vld_m, 1'b0);
    if_rr4.v_vld_s = 4'b1000; if_rr4.v_last_s = 4'b1000; if_rr4.v_pld_s[3] = 8'h73;
    #1 check("mr_src3_rdy", if_rr4.v_rdy_s, 4'b1000);
    @(negedge clk);
    check("mr_src3_vld", if_rr4.vld_m, 1'b1);
    check("mr_src3_id", if_rr4.id_m, 2'd3);
    check("mr_src3_pld", if_rr4.pld_m, 8'h73);
    if_rr4.v_vld_s = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb_rr_lock_pipe.md
# arb_rr_lock_pipe

Parametrised N-to-1 valid/ready arbiter that selects between fixed-priority and round-robin modes through a parameter. It holds a grant for the length of a multi-beat packet, tracked by a per-source last flag. It registers the winning beat in a full-throughput output stage. It sits in front of shared downstream channels where packets from several sources must not interleave and the arbitration path must be cut from the consumer timing.

## Interface
- PLD_TYPE, logic: payload type carried per beat
- WIDTH, 4: number of requesters, minimum 2
- RR_MODE, 1: 0 = fixed priority (index 0 highest), 1 = round-robin
- ID_W, $clog2(WIDTH): width of source id output (derived, do not override)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- v_vld_s  in  WIDTH  per-source valid
- v_rdy_s  out  WIDTH  per-source ready, at most one bit set
- v_pld_s  in  PLD_TYPE[WIDTH]  per-source payload
- v_last_s  in  WIDTH  per-source last-beat-of-packet flag
- vld_m  out  1  registered output valid
- rdy_m  in  1  downstream ready
- pld_m  out  PLD_TYPE  registered payload
- last_m  out  1  registered last flag
- id_m  out  ID_W  registered source index of the beat in pld_m

## Operation
- The output stage is one register holding {pld, last, id, vld}. load = !vld_m || rdy_m.
- Arbitration is combinational each cycle and produces a one-hot grant gnt[WIDTH-1:0]:
  - Locked: gnt = onehot(lock_id) & v_vld_s. No other source is granted, even if lock_id is idle.
  - Unlocked, RR_MODE=0: the lowest-index asserted v_vld_s bit.
  - Unlocked, RR_MODE=1: the first asserted bit at or above ptr, wrapping modulo WIDTH.
- v_rdy_s = gnt & {WIDTH{load}}. accept = |(v_vld_s & v_rdy_s). win = index of gnt.
- On accept, the register loads v_pld_s[win], v_last_s[win], win, and vld_m=1.
- If vld_m && rdy_m && !accept, then vld_m clears to 0.
- Lock state:
  - accept && !v_last_s[win] → lock=1, lock_id=win.
  - accept && v_last_s[win] → lock=0.
  - Single-beat packets (last=1 on the first beat) never lock.
- Round-robin pointer (RR_MODE=1 only):
  - accept && v_last_s[win] → ptr = (win+1) mod WIDTH. Wrap is explicit, so non-power-of-2 WIDTH is legal.
  - ptr does not move mid-packet. It is unused and held at 0 when RR_MODE=0.
- Sources follow valid/ready rules: once asserted, a valid holds with stable payload and last until ready. The block does not check this.
- Reset values: vld_m=0, pld_m='0, last_m=0, id_m=0, lock=0, lock_id=0, ptr=0. v_rdy_s is 0 during reset because gnt is zeroed while rst=1.
- Reset mid-packet discards the buffered beat and the lock. The next packet is arbitrated from a clean state.

## Timing
- Latency: a beat accepted in cycle N appears on vld_m/pld_m in cycle N+1.
- Throughput: 1 beat/cycle when rdy_m is held high, including back-to-back packets from different sources with no bubble.
- Combinational paths:
  - rdy_m → v_rdy_s, through load.
  - v_vld_s → v_rdy_s.
  - No path from inputs to vld_m, pld_m, last_m or id_m.
- Downstream stall: when vld_m=1 and rdy_m=0, v_rdy_s=0 and the output holds stable.
- Simultaneous drain and fill in the same cycle is legal: the register is replaced and vld_m stays 1.
- A locked source deasserting valid between beats inserts bubbles. Other sources stay blocked.

## Test plan
- Reset and idle: assert rst asynchronously mid-cycle → vld_m=0, v_rdy_s=0 immediately. Release with no valids → outputs stay at reset values.
- Fixed priority (RR_MODE=0, WIDTH=4): v_vld_s=4'b1010 held, all single-beat, rdy_m=1 → id_m sequence 1,1,1,... and source 3 is never granted.
- Round-robin (RR_MODE=1, WIDTH=4): v_vld_s=4'b1111 held, single-beat packets, rdy_m=1 → id_m=0,1,2,3,0,... with no bubbles. Repeat with WIDTH=3 → wrap 2→0.
- Packet lock: source 2 sends 3 beats (last on beat 3) while source 0 is valid throughout → id_m=2,2,2, then 0. v_rdy_s[0] is 0 for all 3 cycles. ptr becomes 3 after the last beat.
- Backpressure: random rdy_m at 50% with 4 sources sending 1–5 beat packets → no beat lost or duplicated. Packets are contiguous per id_m. pld_m is stable while vld_m && !rdy_m.
- Reset mid-packet: assert rst after beat 1 of a 3-beat packet from source 1, then present a single-beat request from source 3 → vld_m=0 after reset, then id_m=3 is granted without waiting for source 1.
